// File: rtl/seven_seg_scan_decoder_if.sv
// Display-side bundle: active-low segment/anode lines in, decoded frame and error pulses out.
interface seven_seg_scan_decoder_if;
  logic [6:0]  C_LED;
  logic [3:0]  A_LED;
  logic [15:0] frame_value;
  logic        frame_valid;
  logic [3:0]  digit_valid;
  logic        seg_error;
  logic        anode_error;
  logic        seq_error;

  // master drives the display lines and observes results; slave is the decoder
  modport master (
    output C_LED, A_LED,
    input  frame_value, frame_valid, digit_valid, seg_error, anode_error, seq_error
  );

  modport slave (
    input  C_LED, A_LED,
    output frame_value, frame_valid, digit_valid, seg_error, anode_error, seq_error
  );
endinterface

// File: rtl/seven_seg_scan_decoder.sv
// Decodes a multiplexed active-low 4-digit seven-segment scan back into a 16-bit frame, with error flags.
// Define SEG_DEC_SYNC_EN to add a two-flop input synchroniser (commit latency STABLE_CYCLES+2 instead of STABLE_CYCLES).
module seven_seg_scan_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input logic                    clock,
  input logic                    reset_n,
  seven_seg_scan_decoder_if.slave bus
);

  typedef enum logic {SYNC, COLLECT} state_t;

  logic [10:0] samp;
  logic [10:0] prev;
  logic [7:0]  stab;
  logic        commit;

`ifdef SEG_DEC_SYNC_EN
  logic [10:0] sync1;
  logic [10:0] sync2;

  // Synchroniser resets to the blank pattern so reset release looks like an idle display.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= {bus.A_LED, bus.C_LED};
      sync2 <= sync1;
    end
  end

  assign samp = sync2;
`else
  assign samp = {bus.A_LED, bus.C_LED};
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev <= '1;
      stab <= '0;
    end else begin
      prev <= samp;
      if (samp != prev)
        stab <= '0;
      else if (stab != 8'(STABLE_CYCLES))
        stab <= stab + 8'd1;
    end
  end

  // Saturation keeps stab from revisiting STABLE_CYCLES-1, so one commit per stable window.
  assign commit = (stab == 8'(STABLE_CYCLES - 1));

  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h40:   r = {1'b1, 4'h0};
      7'h79:   r = {1'b1, 4'h1};
      7'h24:   r = {1'b1, 4'h2};
      7'h30:   r = {1'b1, 4'h3};
      7'h19:   r = {1'b1, 4'h4};
      7'h12:   r = {1'b1, 4'h5};
      7'h02:   r = {1'b1, 4'h6};
      7'h78:   r = {1'b1, 4'h7};
      7'h00:   r = {1'b1, 4'h8};
      7'h10:   r = {1'b1, 4'h9};
      7'h08:   r = {1'b1, 4'hA};
      7'h03:   r = {1'b1, 4'hB};
      7'h46:   r = {1'b1, 4'hC};
      7'h21:   r = {1'b1, 4'hD};
      7'h06:   r = {1'b1, 4'hE};
      7'h0E:   r = {1'b1, 4'hF};
      default: r = 5'b0_0000;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] anode_decode(input logic [3:0] an);
    logic [2:0] r;
    case (an)
      4'b1110: r = {1'b1, 2'd0};
      4'b1101: r = {1'b1, 2'd1};
      4'b1011: r = {1'b1, 2'd2};
      4'b0111: r = {1'b1, 2'd3};
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  logic [4:0] seg_dec;
  logic [2:0] an_dec;
  logic       blank;
  logic       seg_ok;
  logic       an_ok;
  logic [3:0] nib;
  logic [1:0] dig;

  assign seg_dec = seg_decode(prev[6:0]);
  assign an_dec  = anode_decode(prev[10:7]);
  assign blank   = (prev[10:7] == 4'hF);
  assign seg_ok  = seg_dec[4];
  assign nib     = seg_dec[3:0];
  assign an_ok   = an_dec[2];
  assign dig     = an_dec[1:0];

  state_t      state;
  logic [1:0]  exp_idx;
  logic [11:0] part;
  logic [15:0] frame_value_q;
  logic        frame_valid_q;
  logic [3:0]  digit_valid_q;
  logic        seg_error_q;
  logic        anode_error_q;
  logic        seq_error_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= SYNC;
      exp_idx       <= 2'd0;
      part          <= '0;
      frame_value_q <= '0;
      frame_valid_q <= 1'b0;
      digit_valid_q <= '0;
      seg_error_q   <= 1'b0;
      anode_error_q <= 1'b0;
      seq_error_q   <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      seg_error_q   <= 1'b0;
      anode_error_q <= 1'b0;
      seq_error_q   <= 1'b0;

      if (commit && !blank) begin
        if (!an_ok) begin
          anode_error_q <= 1'b1;
          state         <= SYNC;
          digit_valid_q <= '0;
        end else if (!seg_ok) begin
          seg_error_q   <= 1'b1;
          state         <= SYNC;
          digit_valid_q <= '0;
        end else begin
          case (state)
            SYNC: begin
              // Digits 1..3 are dropped silently until the scan comes round to digit 0.
              if (dig == 2'd0) begin
                part[3:0]     <= nib;
                digit_valid_q <= 4'b0001;
                exp_idx       <= 2'd1;
                state         <= COLLECT;
              end
            end
            COLLECT: begin
              if (dig != exp_idx) begin
                seq_error_q   <= 1'b1;
                state         <= SYNC;
                digit_valid_q <= '0;
              end else if (dig == 2'd3) begin
                frame_value_q <= {nib, part};
                frame_valid_q <= 1'b1;
                digit_valid_q <= '0;
                exp_idx       <= 2'd0;
              end else begin
                part[4*dig +: 4]   <= nib;
                digit_valid_q[dig] <= 1'b1;
                exp_idx            <= exp_idx + 2'd1;
              end
            end
            default: state <= SYNC;
          endcase
        end
      end
    end
  end

  assign bus.frame_value = frame_value_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.digit_valid = digit_valid_q;
  assign bus.seg_error   = seg_error_q;
  assign bus.anode_error = anode_error_q;
  assign bus.seq_error   = seq_error_q;

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Directed bench for seven_seg_scan_decoder with STABLE_CYCLES=4, synchroniser disabled.
module tb_seven_seg_scan_decoder;

  logic clock;
  logic reset_n;
  int   vectors;
  int   miscompares;
  int   fv_cnt, seg_cnt, an_cnt, seq_cnt;
  int   fv0, seg0, an0, seq0;

  seven_seg_scan_decoder_if bus ();

  seven_seg_scan_decoder #(.STABLE_CYCLES(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Pulse counters, sampled away from the active edge.
  initial begin
    fv_cnt = 0; seg_cnt = 0; an_cnt = 0; seq_cnt = 0;
  end
  always @(negedge clock) begin
    if (reset_n) begin
      if (bus.frame_valid) fv_cnt++;
      if (bus.seg_error)   seg_cnt++;
      if (bus.anode_error) an_cnt++;
      if (bus.seq_error)   seq_cnt++;
    end
  end

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'h40; 4'h1: g = 7'h79; 4'h2: g = 7'h24; 4'h3: g = 7'h30;
      4'h4: g = 7'h19; 4'h5: g = 7'h12; 4'h6: g = 7'h02; 4'h7: g = 7'h78;
      4'h8: g = 7'h00; 4'h9: g = 7'h10; 4'hA: g = 7'h08; 4'hB: g = 7'h03;
      4'hC: g = 7'h46; 4'hD: g = 7'h21; 4'hE: g = 7'h06; default: g = 7'h0E;
    endcase
    return g;
  endfunction

  function automatic logic [3:0] anode(input int d);
    logic [3:0] a;
    a = 4'b0001 << d;
    return ~a;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Present a pattern for n rising edges, then return #1 after the last edge.
  task automatic drive(input logic [3:0] a, input logic [6:0] c, input int n);
    bus.A_LED = a;
    bus.C_LED = c;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic scan_digits(input logic [15:0] v, input int ndig);
    logic [3:0] dv_exp;
    for (int d = 0; d < ndig; d++) begin
      drive(anode(d), glyph(v[4*d +: 4]), 20);
      dv_exp = (d == 3) ? 4'b0000 : 4'((1 << (d + 1)) - 1);
      check($sformatf("dv_after_digit%0d", d), {12'h0, bus.digit_valid}, {12'h0, dv_exp});
    end
  endtask

  task automatic snap;
    fv0 = fv_cnt; seg0 = seg_cnt; an0 = an_cnt; seq0 = seq_cnt;
  endtask

  task automatic full_scan(input string tag, input logic [15:0] v);
    snap();
    scan_digits(v, 4);
    check({tag, "_fv_pulses"}, 16'(fv_cnt - fv0), 16'd1);
    check({tag, "_frame"}, bus.frame_value, v);
    check({tag, "_errors"}, 16'(seg_cnt - seg0 + an_cnt - an0 + seq_cnt - seq0), 16'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    bus.A_LED   = 4'hF;
    bus.C_LED   = 7'h7F;
    reset_n     = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_frame_value", bus.frame_value, 16'h0000);
    check("rst_outputs", {10'h0, bus.frame_valid, bus.seg_error, bus.anode_error,
                          bus.seq_error, 2'b00}, 16'h0000);
    check("rst_digit_valid", {12'h0, bus.digit_valid}, 16'h0000);

    reset_n = 1'b1;
    drive(4'hF, 7'h7F, 10);

    full_scan("normal1", 16'h1234);
    full_scan("normal2", 16'h1234);

    // Commit-to-output latency on the closing digit.
    snap();
    scan_digits(16'h5678, 3);
    drive(anode(3), glyph(4'h5), 4);
    check("lat_fv_early", {15'h0, bus.frame_valid}, 16'h0000);
    drive(anode(3), glyph(4'h5), 1);
    check("lat_fv_pulse", {15'h0, bus.frame_valid}, 16'h0001);
    check("lat_frame", bus.frame_value, 16'h5678);
    drive(anode(3), glyph(4'h5), 1);
    check("lat_fv_single", {15'h0, bus.frame_valid}, 16'h0000);
    drive(anode(3), glyph(4'h5), 14);
    check("lat_fv_count", 16'(fv_cnt - fv0), 16'd1);

    // Short glitch early in digit 2 dwell: no partial window may commit.
    snap();
    drive(anode(0), glyph(4'h4), 20);
    drive(anode(1), glyph(4'h3), 20);
    drive(anode(2), glyph(4'h2), 2);
    drive(anode(2), 7'h7F, 2);
    drive(anode(2), glyph(4'h2), 16);
    check("glitch_dv", {12'h0, bus.digit_valid}, 16'h0007);
    drive(anode(3), glyph(4'h1), 20);
    check("glitch_errors", 16'(seg_cnt - seg0 + an_cnt - an0 + seq_cnt - seq0), 16'd0);
    check("glitch_fv", 16'(fv_cnt - fv0), 16'd1);
    check("glitch_frame", bus.frame_value, 16'h1234);

    full_scan("glyphs_a", 16'hA5C0);
    full_scan("glyphs_b", 16'hF9E8);
    full_scan("glyphs_c", 16'h7D6B);

    // Illegal glyph on digit 1: error, rest of the scan dropped.
    snap();
    drive(anode(0), glyph(4'h4), 20);
    drive(anode(1), 7'h7F, 10);
    check("illegal_dv", {12'h0, bus.digit_valid}, 16'h0000);
    drive(anode(2), glyph(4'h2), 20);
    drive(anode(3), glyph(4'h1), 20);
    check("illegal_seg_err", 16'(seg_cnt - seg0), 16'd1);
    check("illegal_no_fv", 16'(fv_cnt - fv0), 16'd0);
    check("illegal_no_seq", 16'(seq_cnt - seq0), 16'd0);
    check("illegal_frame_kept", bus.frame_value, 16'h7D6B);
    full_scan("illegal_recover", 16'h1234);

    // Bad anode pattern then blanking.
    snap();
    drive(4'b1100, glyph(4'h0), 10);
    check("anode_err", 16'(an_cnt - an0), 16'd1);
    check("anode_dv", {12'h0, bus.digit_valid}, 16'h0000);
    drive(4'b1111, 7'h7F, 10);
    drive(4'b1111, glyph(4'h8), 10);
    check("blank_no_err", 16'(an_cnt - an0 + seg_cnt - seg0), 16'd1);

    // Out-of-order scan 0,1,3.
    snap();
    drive(anode(0), glyph(4'h4), 20);
    drive(anode(1), glyph(4'h3), 20);
    drive(anode(3), glyph(4'h1), 20);
    check("seq_err", 16'(seq_cnt - seq0), 16'd1);
    check("seq_dv", {12'h0, bus.digit_valid}, 16'h0000);
    check("seq_no_fv", 16'(fv_cnt - fv0), 16'd0);
    full_scan("seq_recover", 16'h4321);

    // Reset in the middle of a frame.
    scan_digits(16'h1234, 3);
    reset_n = 1'b0;
    #1;
    check("midrst_frame", bus.frame_value, 16'h0000);
    check("midrst_dv", {12'h0, bus.digit_valid}, 16'h0000);
    check("midrst_pulses", {12'h0, bus.frame_valid, bus.seg_error, bus.anode_error,
                            bus.seq_error}, 16'h0000);
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    drive(anode(2), glyph(4'h2), 10);
    full_scan("midrst_recover", 16'h1234);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
